hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl_pkg.sv | 26 ++
 rtl/hazard_cmp.sv | 25 ++
 rtl/hazard_stall_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the load-use hazard stall controller.
package hazard_stall_ctrl_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      LDSTALL = 1'b1
   } state_e;

   // Pipeline-control bundle: {pcen, ifiden, idexen, ctrlsig, ifidflush}
   typedef struct packed {
      logic pcen;
      logic ifiden;
      logic idexen;
      logic ctrlsig;
      logic ifidflush;
   } ctrl_t;

   // ctrlsig value that loads NOP controls into ID/EX
   localparam logic NOP_CTRL = 1'b1;

   localparam ctrl_t CTRL_RUN    = '{pcen: 1'b1, ifiden: 1'b1, idexen: 1'b1, ctrlsig: 1'b0,     ifidflush: 1'b0};
   localparam ctrl_t CTRL_FREEZE = '{pcen: 1'b0, ifiden: 1'b0, idexen: 1'b0, ctrlsig: 1'b0,     ifidflush: 1'b0};
   localparam ctrl_t CTRL_BUBBLE = '{pcen: 1'b0, ifiden: 1'b0, idexen: 1'b1, ctrlsig: NOP_CTRL, ifidflush: 1'b0};
   localparam ctrl_t CTRL_FLUSH  = '{pcen: 1'b1, ifiden: 1'b1, idexen: 1'b1, ctrlsig: NOP_CTRL, ifidflush: 1'b1};

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard comparator: EX-stage load destination against the ID-stage sources.
module hazard_cmp #(
   parameter int AW          = 5,
   parameter int ZERO_EXEMPT = 1
) (
   input  logic [AW-1:0] idexrt,
   input  logic          idexmemrd,
   input  logic [AW-1:0] ifidrs,
   input  logic [AW-1:0] ifidrt,
   input  logic          ifidusers,
   input  logic          ifidusert,
   output logic          hz
);

   logic w_rs_hit;
   logic w_rt_hit;
   logic w_exempt;

   assign w_rs_hit = ifidusers && (ifidrs == idexrt);
   assign w_rt_hit = ifidusert && (ifidrt == idexrt);
   // r0 is hardwired, so a load "into" it never produces a real dependency
   assign w_exempt = (ZERO_EXEMPT != 0) && (idexrt == '0);
   assign hz       = idexmemrd && (w_rs_hit || w_rt_hit) && !w_exempt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall controller: inserts LOAD_LAT bubbles per hazard, honours freeze and flush.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int AW          = 5,
   parameter int LOAD_LAT    = 1,   // legal 1..3
   parameter int ZERO_EXEMPT = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    idexrt,
   input  logic             idexmemrd,
   input  logic [AW-1:0]    ifidrs,
   input  logic [AW-1:0]    ifidrt,
   input  logic             ifidusers,
   input  logic             ifidusert,
   input  logic             membusy,
   input  logic             flush,
   output logic             pcen,
   output logic             ifiden,
   output logic             idexen,
   output logic             ctrlsig,
   output logic             ifidflush,
   output logic [1:0]       stallcnt,
   output logic [CNT_W-1:0] bubbles
);

   localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [1:0]       r_stallcnt;
   logic [1:0]       w_stallcnt_nxt;
   logic [CNT_W-1:0] r_bubbles;
   logic             w_hz;
   logic             w_bubble;
   ctrl_t            w_ctrl;

   hazard_cmp #(
      .AW          (AW),
      .ZERO_EXEMPT (ZERO_EXEMPT)
   ) u_cmp (
      .idexrt    (idexrt),
      .idexmemrd (idexmemrd),
      .ifidrs    (ifidrs),
      .ifidrt    (ifidrt),
      .ifidusers (ifidusers),
      .ifidusert (ifidusert),
      .hz        (w_hz)
   );

   always_comb begin
      w_ctrl         = CTRL_RUN;
      w_state_nxt    = r_state;
      w_stallcnt_nxt = r_stallcnt;
      w_bubble       = 1'b0;
      if (!rst_n) begin
         // outputs must read as free-running while reset is held, whatever the inputs
         w_ctrl         = CTRL_RUN;
         w_state_nxt    = IDLE;
         w_stallcnt_nxt = 2'd0;
      end else if (membusy) begin
         w_ctrl = CTRL_FREEZE;
      end else if (flush) begin
         w_ctrl         = CTRL_FLUSH;
         w_state_nxt    = IDLE;
         w_stallcnt_nxt = 2'd0;
         w_bubble       = 1'b1;
      end else if (r_state == LDSTALL) begin
         w_ctrl   = CTRL_BUBBLE;
         w_bubble = 1'b1;
         if (r_stallcnt <= 2'd1) begin
            w_state_nxt    = IDLE;
            w_stallcnt_nxt = 2'd0;
         end else begin
            w_stallcnt_nxt = r_stallcnt - 2'd1;
         end
      end else if (w_hz) begin
         w_ctrl   = CTRL_BUBBLE;
         w_bubble = 1'b1;
         if (LOAD_LAT > 1) begin
            w_state_nxt    = LDSTALL;
            w_stallcnt_nxt = LAT_M1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_stallcnt <= 2'd0;
         r_bubbles  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_stallcnt <= w_stallcnt_nxt;
         if (w_bubble && (r_bubbles != '1))
            r_bubbles <= r_bubbles + CNT_W'(1);
      end
   end

   assign pcen      = w_ctrl.pcen;
   assign ifiden    = w_ctrl.ifiden;
   assign idexen    = w_ctrl.idexen;
   assign ctrlsig   = w_ctrl.ctrlsig;
   assign ifidflush = w_ctrl.ifidflush;
   assign stallcnt  = r_stallcnt;
   assign bubbles   = r_bubbles;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: three configurations share one stimulus stream, checked against an owed-bubble model.
module tb_hazard_stall_ctrl;

   localparam int N = 3;

   typedef struct packed {
      logic       r;
      logic [4:0] rt;
      logic       mr;
      logic [4:0] rs;
      logic [4:0] rtt;
      logic       urs;
      logic       urt;
      logic       mb;
      logic       fl;
   } stim_t;

   // c = {pcen, ifiden, idexen, ctrlsig, ifidflush}
   typedef struct packed {
      logic [N-1:0][4:0]  c;
      logic [N-1:0][1:0]  sc;
      logic [N-1:0][15:0] bub;
      int unsigned        cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   logic [4:0] idexrt, ifidrs, ifidrt;
   logic idexmemrd, ifidusers, ifidusert, membusy, flush;
   logic [N-1:0] pcen, ifiden, idexen, ctrlsig, ifidflush;
   logic [N-1:0][1:0] sc;
   logic [15:0] b0, b1;
   logic [1:0]  b2;
   logic [N-1:0][15:0] bub_act;

   assign bub_act[0] = b0;
   assign bub_act[1] = b1;
   assign bub_act[2] = {14'd0, b2};

   exp_t q[$];
   int total = 0;
   int bad = 0;
   int unsigned cyc = 0;
   int rem[N];
   int unsigned bub[N];

   function automatic int ll(int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
   endfunction
   function automatic bit ze(int k);
      return (k != 0);
   endfunction
   function automatic int unsigned cmax(int k);
      return (k == 2) ? 32'd3 : 32'd65535;
   endfunction

   hazard_stall_ctrl #(.AW(5), .LOAD_LAT(1), .ZERO_EXEMPT(0), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .idexrt(idexrt), .idexmemrd(idexmemrd),
      .ifidrs(ifidrs), .ifidrt(ifidrt), .ifidusers(ifidusers), .ifidusert(ifidusert),
      .membusy(membusy), .flush(flush), .pcen(pcen[0]), .ifiden(ifiden[0]),
      .idexen(idexen[0]), .ctrlsig(ctrlsig[0]), .ifidflush(ifidflush[0]),
      .stallcnt(sc[0]), .bubbles(b0));

   hazard_stall_ctrl #(.AW(5), .LOAD_LAT(3), .ZERO_EXEMPT(1), .CNT_W(16)) u1 (
      .clk(clk), .rst_n(rst_n), .idexrt(idexrt), .idexmemrd(idexmemrd),
      .ifidrs(ifidrs), .ifidrt(ifidrt), .ifidusers(ifidusers), .ifidusert(ifidusert),
      .membusy(membusy), .flush(flush), .pcen(pcen[1]), .ifiden(ifiden[1]),
      .idexen(idexen[1]), .ctrlsig(ctrlsig[1]), .ifidflush(ifidflush[1]),
      .stallcnt(sc[1]), .bubbles(b1));

   hazard_stall_ctrl #(.AW(5), .LOAD_LAT(2), .ZERO_EXEMPT(1), .CNT_W(2)) u2 (
      .clk(clk), .rst_n(rst_n), .idexrt(idexrt), .idexmemrd(idexmemrd),
      .ifidrs(ifidrs), .ifidrt(ifidrt), .ifidusers(ifidusers), .ifidusert(ifidusert),
      .membusy(membusy), .flush(flush), .pcen(pcen[2]), .ifiden(ifiden[2]),
      .idexen(idexen[2]), .ctrlsig(ctrlsig[2]), .ifidflush(ifidflush[2]),
      .stallcnt(sc[2]), .bubbles(b2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic stim_t st(logic r, logic [4:0] rt, logic mr, logic [4:0] rs,
                                logic [4:0] rtt, logic urs, logic urt, logic mb, logic fl);
      stim_t s;
      s = '{r: r, rt: rt, mr: mr, rs: rs, rtt: rtt, urs: urs, urt: urt, mb: mb, fl: fl};
      return s;
   endfunction

   // Model: each config owes a number of further bubble cycles; a frozen cycle owes nothing new
   task automatic drive(input stim_t s);
      exp_t e;
      logic h;
      @(posedge clk);
      #1;
      rst_n = s.r; idexrt = s.rt; idexmemrd = s.mr; ifidrs = s.rs; ifidrt = s.rtt;
      ifidusers = s.urs; ifidusert = s.urt; membusy = s.mb; flush = s.fl;
      e = '0;
      e.cyc = cyc;
      for (int k = 0; k < N; k++) begin
         h = s.mr && ((s.urs && s.rs == s.rt) || (s.urt && s.rtt == s.rt)) && !(ze(k) && s.rt == 5'd0);
         e.sc[k]  = 2'(rem[k]);
         e.bub[k] = 16'(bub[k]);
         if (!s.r) begin
            e.c[k] = 5'b11100; e.sc[k] = 2'd0; e.bub[k] = 16'd0;
            rem[k] = 0; bub[k] = 0;
         end else if (s.mb) begin
            e.c[k] = 5'b00000;
         end else if (s.fl) begin
            e.c[k] = 5'b11111;
            rem[k] = 0;
            if (bub[k] < cmax(k)) bub[k]++;
         end else if (rem[k] > 0 || h) begin
            e.c[k] = 5'b00110;
            rem[k] = (rem[k] > 0) ? rem[k] - 1 : ll(k) - 1;
            if (bub[k] < cmax(k)) bub[k]++;
         end else begin
            e.c[k] = 5'b11100;
         end
      end
      q.push_back(e);
      cyc++;
   endtask

   task automatic chk(input string nm, input int unsigned got, input int unsigned want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   // Monitor: every cycle the DUTs present a full set of outputs
   initial begin
      exp_t e;
      logic [4:0] a;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e = q.pop_front();
            for (int k = 0; k < N; k++) begin
               a = {pcen[k], ifiden[k], idexen[k], ctrlsig[k], ifidflush[k]};
               total++;
               if (a !== e.c[k] || sc[k] !== e.sc[k] || bub_act[k] !== e.bub[k]) begin
                  bad++;
                  $display("FAIL inst%0d cyc%0d pc/if/ex/ct/fl got=%b want=%b stallcnt got=%0d want=%0d bubbles got=%0d want=%0d",
                           k, e.cyc, a, e.c[k], sc[k], e.sc[k], bub_act[k], e.bub[k]);
               end
            end
         end
      end
   end

   initial begin
      stim_t R, H, N0, Z, B, F, s;
      for (int k = 0; k < N; k++) begin rem[k] = 0; bub[k] = 0; end
      rst_n = 1'b0; idexrt = '0; idexmemrd = 1'b0; ifidrs = '0; ifidrt = '0;
      ifidusers = 1'b0; ifidusert = 1'b0; membusy = 1'b0; flush = 1'b0;
      // reset held with a busy/flush/hazard input pattern still reads as free-running
      R  = st(1'b0, 5'd8, 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      H  = st(1'b1, 5'd8, 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      N0 = st(1'b1, 5'd8, 1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      Z  = st(1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      B  = st(1'b1, 5'd8, 1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      F  = st(1'b1, 5'd8, 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);

      drive(R); drive(R);
      // single hazard: 1, 3 and 2 bubbles for the three latencies
      drive(H); repeat (3) drive(N0);
      @(negedge clk);
      chk("lat_bubbles_u0", b0, 1); chk("lat_bubbles_u1", b1, 3); chk("lat_bubbles_u2", b2, 2);

      // r0 destination: only the non-exempt config stalls
      drive(R); drive(Z); repeat (2) drive(N0);
      @(negedge clk);
      chk("zero_u0", b0, 1); chk("zero_u1", b1, 0); chk("zero_u2", b2, 0);

      // freeze mid-stall
      drive(R); drive(H); drive(B); drive(B); repeat (3) drive(N0);
      @(negedge clk);
      chk("freeze_u1", b1, 3); chk("freeze_u2", b2, 2);

      // flush together with hazard
      drive(R); drive(F); repeat (2) drive(N0);
      @(negedge clk);
      chk("flush_u1", b1, 1);

      // saturation of the narrow counter
      drive(R);
      repeat (5) begin drive(H); repeat (3) drive(N0); end
      @(negedge clk);
      chk("sat_u0", b0, 5); chk("sat_u1", b1, 15); chk("sat_u2", b2, 3);

      // reset in the middle of a stall
      drive(R); drive(H); drive(N0); drive(R); repeat (2) drive(N0);
      @(negedge clk);
      chk("rst_abort_u1", b1, 0); chk("rst_abort_sc_u1", sc[1], 0);

      repeat (3000) begin
         s.r   = ($urandom_range(0, 99) != 0);
         s.rt  = 5'($urandom_range(0, 3));
         s.mr  = ($urandom_range(0, 1) != 0);
         s.rs  = 5'($urandom_range(0, 3));
         s.rtt = 5'($urandom_range(0, 3));
         s.urs = ($urandom_range(0, 9) < 7);
         s.urt = ($urandom_range(0, 9) < 7);
         s.mb  = ($urandom_range(0, 9) == 0);
         s.fl  = ($urandom_range(0, 11) == 0);
         drive(s);
      end

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
